// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit pipeline.
// Computes ALUResult/R15Result. Single-cycle ops are combinational. Signed MUL and DIV
// run on a shared iterative datapath with one step per cycle, for ITER cycles in total.
// While a MUL/DIV runs, the stage holds the front of the pipeline with `stall`.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inValid, aluOp      instruction valid, operation select
//   op1Val, op2Val      operands
//   regOp1/2, wb, mem   passed through (wb/mem gated)
//   ALUResult, R15Result primary / secondary result
//   outOp1Val.. outMem  pass-through outputs
//   stall               freeze PC, IF/ID, ID/EX
//   o_dbg_state         current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// Handshake: an instruction is a request while inValid=1. While stall=1 the upstream
// holds every input stable. Results are consumed by EX/MEM on any edge where stall=0.
module ex_stage #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  input  logic [3:0]       aluOp,
  input  logic [WIDTH-1:0] op1Val,
  input  logic [WIDTH-1:0] op2Val,
  input  logic [3:0]       regOp1,
  input  logic [3:0]       regOp2,
  input  logic             wb,
  input  logic             mem,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] R15Result,
  output logic [WIDTH-1:0] outOp1Val,
  output logic [WIDTH-1:0] outOp2Val,
  output logic [3:0]       outRegOp1,
  output logic [3:0]       outRegOp2,
  output logic             outWB,
  output logic             outMem,
  output logic             stall,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_SLL = 4'd4, OP_SRL = 4'd5, OP_SRA = 4'd6, OP_MUL = 4'd7,
                         OP_DIV = 4'd8;
  localparam int               CNT_W = $clog2(ITER) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITER - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;      // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;      // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] r_b;       // multiplicand / divisor magnitude
  logic             r_is_div;
  logic             r_neg_q;   // negate product or quotient
  logic             r_neg_r;   // negate remainder (dividend was negative)
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;

  logic [WIDTH-1:0]   w_comb_res;
  logic               w_start;
  logic [WIDTH-1:0]   w_mag1, w_mag2;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_diff;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_step_hi, w_step_lo;
  logic [2*WIDTH-1:0] w_prod_mag, w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;

  // Single-cycle ALU; MUL/DIV show 0 here since their result only appears in DONE.
  always_comb begin
    w_comb_res = '0;
    case (aluOp)
      OP_ADD:         w_comb_res = op1Val + op2Val;
      OP_SUB:         w_comb_res = op1Val - op2Val;
      OP_AND:         w_comb_res = op1Val & op2Val;
      OP_OR:          w_comb_res = op1Val | op2Val;
      OP_SLL:         w_comb_res = op1Val << op2Val[3:0];
      OP_SRL:         w_comb_res = op1Val >> op2Val[3:0];
      OP_SRA:         w_comb_res = $signed(op1Val) >>> op2Val[3:0];
      OP_MUL, OP_DIV: w_comb_res = '0;
      default:        w_comb_res = op2Val;
    endcase
  end

  assign w_start = (r_state == S_IDLE) && inValid && (aluOp == OP_MUL || aluOp == OP_DIV);

  // Magnitudes as unsigned values; -32768 maps to 0x8000, which is still exact.
  assign w_mag1 = op1Val[WIDTH-1] ? (~op1Val + 1'b1) : op1Val;
  assign w_mag2 = op2Val[WIDTH-1] ? (~op2Val + 1'b1) : op2Val;

  // Shift-add multiply step: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift {hi, lo} right by one.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Restoring divide step: shift the next dividend bit into the remainder and subtract.
  // The 18-bit difference has a clear top bit exactly when the subtraction fits.
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
  assign w_div_ok    = ~w_div_diff[WIDTH+1];

  always_comb begin
    if (r_is_div) begin
      w_step_hi = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_step_lo = {r_lo[WIDTH-2:0], w_div_ok};
    end else begin
      w_step_hi = w_mul_sum[WIDTH:1];
      w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Sign correction on the values produced by the final step.
  assign w_prod_mag = {w_step_hi, w_step_lo};
  assign w_prod     = r_neg_q ? (~w_prod_mag + 1'b1) : w_prod_mag;
  assign w_quot     = r_neg_q ? (~w_step_lo + 1'b1) : w_step_lo;
  assign w_rem      = r_neg_r ? (~w_step_hi + 1'b1) : w_step_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_res_lo <= '0;
      r_res_hi <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= w_mag1;
            r_b      <= w_mag2;
            r_is_div <= (aluOp == OP_DIV);
            r_neg_q  <= op1Val[WIDTH-1] ^ op2Val[WIDTH-1];
            r_neg_r  <= op1Val[WIDTH-1];
            if (aluOp == OP_DIV && op2Val == '0) begin
              r_res_lo <= '1;
              r_res_hi <= op1Val;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_res_lo <= r_is_div ? w_quot : w_prod[WIDTH-1:0];
            r_res_hi <= r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
            r_state  <= S_DONE;
          end
        end
        // The held instruction is not a new request; always release the pipeline.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall       = w_start || (r_state == S_BUSY);
  assign ALUResult   = (r_state == S_DONE) ? r_res_lo : w_comb_res;
  assign R15Result   = (r_state == S_DONE) ? r_res_hi : '0;
  assign outOp1Val   = op1Val;
  assign outOp2Val   = op2Val;
  assign outRegOp1   = regOp1;
  assign outRegOp2   = regOp2;
  assign outWB       = wb  & inValid & ~stall;
  assign outMem      = mem & inValid & ~stall;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  alu_op;
  logic [15:0] op1, op2;
  logic [3:0]  reg1, reg2;
  logic        wb, mem;
  logic [15:0] alu_res, r15_res, out_op1, out_op2;
  logic [3:0]  out_reg1, out_reg2;
  logic        out_wb, out_mem, stall;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  ex_stage #(.WIDTH(16), .ITER(16)) dut (
    .clk(clk), .rst(rst), .inValid(in_valid), .aluOp(alu_op),
    .op1Val(op1), .op2Val(op2), .regOp1(reg1), .regOp2(reg2),
    .wb(wb), .mem(mem),
    .ALUResult(alu_res), .R15Result(r15_res),
    .outOp1Val(out_op1), .outOp2Val(out_op2),
    .outRegOp1(out_reg1), .outRegOp2(out_reg2),
    .outWB(out_wb), .outMem(out_mem), .stall(stall), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: inputs change 1 ns after the rising edge, outputs sampled on the falling edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic v);
    in_valid = v;
    alu_op   = op;
    op1      = a;
    op2      = b;
    wb       = 1'b1;
    mem      = 1'b1;
    reg1     = 4'd3;
    reg2     = 4'd9;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if (stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall); else n_pass++;
    n_total++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d want 0", dbg_state); else n_pass++;
    n_total++;
    if (r15_res !== 16'h0) $display("FAIL reset_r15 got %h want 0000", r15_res); else n_pass++;
    n_total++;
    if (out_wb !== 1'b0) $display("FAIL reset_outwb got %0b want 0", out_wb); else n_pass++;
    next_cycle();
  endtask

  task automatic test_single(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp, input string name);
    issue(op, a, b, 1'b1);
    @(negedge clk);
    n_total++;
    if (alu_res !== exp || r15_res !== 16'h0 || stall !== 1'b0)
      $display("FAIL %s got alu=%h r15=%h stall=%0b want alu=%h r15=0000 stall=0",
               name, alu_res, r15_res, stall, exp);
    else n_pass++;
    n_total++;
    if (out_wb !== 1'b1 || out_mem !== 1'b1 || out_op1 !== a || out_op2 !== b ||
        out_reg1 !== 4'd3 || out_reg2 !== 4'd9)
      $display("FAIL %s_pass got wb=%0b mem=%0b op1=%h op2=%h want 1 1 %h %h",
               name, out_wb, out_mem, out_op1, out_op2, a, b);
    else n_pass++;
    next_cycle();
  endtask

  // Issue a MUL/DIV in the current cycle, count stall cycles, check the DONE cycle,
  // and return positioned at the start of the following IDLE cycle.
  task automatic run_multi(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_lo, input logic [15:0] exp_hi,
                           input int exp_stalls, input string name);
    int  n_stall;
    int  gate_bad;
    bit  done;
    n_stall  = 0;
    gate_bad = 0;
    done     = 0;
    issue(op, a, b, 1'b1);
    while (!done) begin
      @(negedge clk);
      if (!stall || n_stall > 40) begin
        done = 1;
      end else begin
        n_stall++;
        if (out_wb !== 1'b0 || out_mem !== 1'b0) gate_bad++;
        next_cycle();
      end
    end
    n_total++;
    if (n_stall !== exp_stalls)
      $display("FAIL %s_stall_cycles got %0d want %0d", name, n_stall, exp_stalls);
    else n_pass++;
    n_total++;
    if (alu_res !== exp_lo || r15_res !== exp_hi)
      $display("FAIL %s_result got %h/%h want %h/%h", name, alu_res, r15_res, exp_lo, exp_hi);
    else n_pass++;
    n_total++;
    if (gate_bad !== 0 || out_wb !== 1'b1 || out_mem !== 1'b1 || dbg_state !== 2'd2)
      $display("FAIL %s_gate got bad=%0d wb=%0b mem=%0b state=%0d want 0 1 1 2",
               name, gate_bad, out_wb, out_mem, dbg_state);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_invalid();
    issue(4'd7, 16'h0003, 16'h0005, 1'b0);
    @(negedge clk);
    n_total++;
    if (stall !== 1'b0 || out_wb !== 1'b0 || out_mem !== 1'b0)
      $display("FAIL invalid_gate got stall=%0b wb=%0b mem=%0b want 0 0 0", stall, out_wb, out_mem);
    else n_pass++;
    next_cycle();
    issue(4'd0, 16'h0011, 16'h0022, 1'b0);
    @(negedge clk);
    n_total++;
    if (dbg_state !== 2'd0 || alu_res !== 16'h0033 || out_wb !== 1'b0)
      $display("FAIL invalid_idle got state=%0d alu=%h wb=%0b want 0 0033 0",
               dbg_state, alu_res, out_wb);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_abort();
    issue(4'd7, 16'hFFFD, 16'h0005, 1'b1);
    repeat (5) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (stall !== 1'b1 || dbg_state !== 2'd1)
      $display("FAIL abort_busy got stall=%0b state=%0d want 1 1", stall, dbg_state);
    else n_pass++;
    next_cycle();
    rst = 1'b0;
    issue(4'd0, 16'h0002, 16'h0002, 1'b1);
    @(negedge clk);
    n_total++;
    if (dbg_state !== 2'd0 || stall !== 1'b0 || alu_res !== 16'h0004 || r15_res !== 16'h0)
      $display("FAIL abort_recover got state=%0d stall=%0b alu=%h r15=%h want 0 0 0004 0000",
               dbg_state, stall, alu_res, r15_res);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    run_multi(4'd7, 16'h0007, 16'hFFFA, 16'hFFD6, 16'hFFFF, 17, "b2b_mul1");
    run_multi(4'd7, 16'd300,  16'd300,  16'h5F90, 16'h0001, 17, "b2b_mul2");
  endtask

  initial begin
    rst = 1'b1;
    issue(4'd0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single(4'd0, 16'h7FFF, 16'h0001, 16'h8000, "add_ovf");
    test_single(4'd1, 16'h0005, 16'h0007, 16'hFFFE, "sub");
    test_single(4'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, "and");
    test_single(4'd3, 16'h1200, 16'h0034, 16'h1234, "or");
    test_single(4'd4, 16'h0001, 16'h001F, 16'h8000, "sll");
    test_single(4'd5, 16'h8000, 16'h0004, 16'h0800, "srl");
    test_single(4'd6, 16'h8000, 16'h0003, 16'hF000, "sra");
    test_single(4'd12, 16'h1111, 16'hBEEF, 16'hBEEF, "move");
    test_invalid();
    run_multi(4'd7, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 17, "mul_neg");
    run_multi(4'd7, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 17, "mul_big");
    run_multi(4'd8, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 17, "div_neg");
    run_multi(4'd8, 16'd100,  16'd7,    16'h000E, 16'h0002, 17, "div_pos");
    run_multi(4'd8, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 17, "div_ovf");
    run_multi(4'd8, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1,  "div_zero");
    test_abort();
    test_back_to_back();
    test_single(4'd0, 16'h0002, 16'h0002, 16'h0004, "add_after");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
